// File: rtl/serial_sub_pkg.sv
// Shared FSM encodings for the bit-serial subtractor.
package serial_sub_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_sub_onebit.sv
// Single-bit full subtractor cell: d = a - b - bin, bout set on borrow.
module onebit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one onebit cell with a
// registered borrow loop and a start/busy/done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  onebit u_cell (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_bin  (r_brw),
    .o_d    (w_d),
    .o_bout (w_bo)
  );

  // New bit enters at the MSB; the oldest LSB falls off the bottom.
  assign w_res_next = WIDTH'({w_d, r_res} >> 1);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a_sr  <= a_in;
            r_b_sr  <= b_in;
            r_brw   <= bin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_res  <= w_res_next;
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_brw  <= w_bo;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bo;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=2 and WIDTH=4.
module tb_serial_sub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2_n, start2, bin2_i, busy2, done2, bout2;
  logic [1:0] a2, b2, diff2;
  logic       rst4_n, start4, bin4_i, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  serial_sub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .a_in(a2), .b_in(b2),
    .bin(bin2_i), .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  serial_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .a_in(a4), .b_in(b4),
    .bin(bin4_i), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  typedef struct {
    logic [3:0] diff;
    logic       bout;
  } exp_t;

  typedef struct {
    int         w;
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  exp_t q2[$];
  exp_t q4[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input int w, input int a, input int b, input int bi);
    exp_t e;
    int   r;
    r      = a - b - bi;
    e.diff = 4'(r & ((1 << w) - 1));
    e.bout = (a < (b + bi));
    return e;
  endfunction

  // Output monitors: protocol checks and scoreboard pops on done.
  logic       prev_done2 = 1'b0, prev_done4 = 1'b0;
  logic [1:0] prev_diff2 = '0;
  logic [3:0] prev_diff4 = '0;

  always @(negedge clk) begin
    if (rst2_n) begin
      if (busy2 || done2) chk("busy_done_excl2", busy2 & done2, 0);
      if (done2)          chk("done_width2", prev_done2, 0);
      if (busy2)          chk("diff_stable2", diff2, prev_diff2);
      if (done2) begin
        if (q2.size() == 0) chk("unexpected_done2", 1, 0);
        else begin
          exp_t e;
          e = q2.pop_front();
          chk("diff2", diff2, e.diff);
          chk("bout2", bout2, e.bout);
        end
      end
    end
    prev_done2 = rst2_n ? done2 : 1'b0;
    prev_diff2 = diff2;
  end

  always @(negedge clk) begin
    if (rst4_n) begin
      if (busy4 || done4) chk("busy_done_excl4", busy4 & done4, 0);
      if (done4)          chk("done_width4", prev_done4, 0);
      if (busy4)          chk("diff_stable4", diff4, prev_diff4);
      if (done4) begin
        if (q4.size() == 0) chk("unexpected_done4", 1, 0);
        else begin
          exp_t e;
          e = q4.pop_front();
          chk("diff4", diff4, e.diff);
          chk("bout4", bout4, e.bout);
        end
      end
    end
    prev_done4 = rst4_n ? done4 : 1'b0;
    prev_diff4 = diff4;
  end

  task automatic wait_q2();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (q2.size() == 0) break;
    end
    chk("timeout2_pending", q2.size(), 0);
    q2.delete();
  endtask

  task automatic wait_q4();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (q4.size() == 0) break;
    end
    chk("timeout4_pending", q4.size(), 0);
    q4.delete();
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi, input exp_t e);
    @(negedge clk);
    a2 = a; b2 = b; bin2_i = bi; start2 = 1'b1;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    wait_q2();
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi, input exp_t e);
    @(negedge clk);
    a4 = a; b4 = b; bin4_i = bi; start4 = 1'b1;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    wait_q4();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    logic [3:0] b2b_a[3];
    logic [3:0] b2b_b[3];
    logic       b2b_i[3];

    vecs[0] = '{2, 4'd3, 4'd1,  1'b0, 4'd2,  1'b0};
    vecs[1] = '{2, 4'd1, 4'd2,  1'b0, 4'd3,  1'b1};
    vecs[2] = '{2, 4'd0, 4'd0,  1'b1, 4'd3,  1'b1};
    vecs[3] = '{2, 4'd2, 4'd1,  1'b1, 4'd0,  1'b0};
    vecs[4] = '{4, 4'd9, 4'd12, 1'b0, 4'd13, 1'b1};
    vecs[5] = '{4, 4'd5, 4'd3,  1'b0, 4'd2,  1'b0};
    vecs[6] = '{4, 4'd15, 4'd0, 1'b1, 4'd14, 1'b0};
    vecs[7] = '{4, 4'd0, 4'd15, 1'b1, 4'd0,  1'b1};

    rst2_n = 1'b0; rst4_n = 1'b0;
    start2 = 1'b0; start4 = 1'b0;
    a2 = '0; b2 = '0; bin2_i = 1'b0;
    a4 = '0; b4 = '0; bin4_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy2", busy2, 0); chk("rst_done2", done2, 0);
    chk("rst_diff2", diff2, 0); chk("rst_bout2", bout2, 0);
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0);
    chk("rst_diff4", diff4, 0); chk("rst_bout4", bout4, 0);
    rst2_n = 1'b1; rst4_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset2", busy2, 0);
    chk("idle_after_reset4", busy4, 0);

    // Latency: 3 - 1 with busy for two cycles, done on the third.
    a2 = 2'd3; b2 = 2'd1; bin2_i = 1'b0; start2 = 1'b1;
    q2.push_back(model(2, 3, 1, 0));
    @(negedge clk);
    start2 = 1'b0;
    chk("lat_busy_c1", busy2, 1);
    @(negedge clk);
    chk("lat_busy_c2", busy2, 1);
    @(negedge clk);
    chk("lat_done_c3", done2, 1);
    chk("lat_notbusy_c3", busy2, 0);
    wait_q2();

    for (int i = 0; i < 8; i++) begin
      e.diff = vecs[i].exp_diff;
      e.bout = vecs[i].exp_bout;
      if (vecs[i].w == 2) op2(vecs[i].a[1:0], vecs[i].b[1:0], vecs[i].bi, e);
      else                op4(vecs[i].a, vecs[i].b, vecs[i].bi, e);
    end

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int bi = 0; bi < 2; bi++)
          op2(2'(a), 2'(b), 1'(bi), model(2, a, b, bi));

    // Start held high: results every WIDTH+1 cycles with no idle gap.
    b2b_a = '{4'd9, 4'd7, 4'd3};
    b2b_b = '{4'd12, 4'd2, 4'd8};
    b2b_i = '{1'b0, 1'b1, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      a4 = b2b_a[k]; b4 = b2b_b[k]; bin4_i = b2b_i[k]; start4 = 1'b1;
      q4.push_back(model(4, int'(b2b_a[k]), int'(b2b_b[k]), int'(b2b_i[k])));
      repeat (5) begin
        @(negedge clk);
        chk("b2b_active", busy4 | done4, 1);
      end
    end
    start4 = 1'b0;
    wait_q4();

    // Start mid-run with different operands is ignored.
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd12; bin4_i = 1'b0; start4 = 1'b1;
    q4.push_back(model(4, 9, 12, 0));
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; bin4_i = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_q4();
    repeat (8) @(negedge clk);
    chk("no_extra_result4", q4.size(), 0);

    // Asynchronous reset in the middle of a run.
    a4 = 4'd15; b4 = 4'd0; bin4_i = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst4_n = 1'b0;
    #1;
    chk("arst_busy4", busy4, 0);
    chk("arst_done4", done4, 0);
    chk("arst_diff4", diff4, 0);
    chk("arst_bout4", bout4, 0);
    @(negedge clk);
    rst4_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_done4", done4, 0);
    op4(4'd5, 4'd3, 1'b0, model(4, 5, 3, 0));

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
